// File: rtl/axi_mem_responder.sv
// AXI-style memory slave: independent write and read FSMs over one word-addressed RAM.
// Define AXI_MEM_BACKPRESSURE_EN to add LFSR-driven READY/RVALID throttling.
module axi_mem_responder #(
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MEM_WORDS_LOG2 = 16,
  parameter int unsigned READ_LATENCY   = 2,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [3:0]            AWID,
  input  logic [3:0]            AWLEN,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic                  WVALID,
  output logic                  WREADY,
  input  logic                  WLAST,
  input  logic [3:0]            WID,
  input  logic [DATA_WIDTH-1:0] WDATA,
  output logic                  BVALID,
  input  logic                  BREADY,
  output logic [3:0]            BID,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  input  logic [3:0]            ARID,
  input  logic [3:0]            ARLEN,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic                  RLAST,
  output logic [3:0]            RID,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  proto_err
);
  localparam int unsigned IdxW  = MEM_WORDS_LOG2;
  localparam int unsigned Depth = 2 ** MEM_WORDS_LOG2;

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RWait, RBurst} r_state_e;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  w_state_e        w_state_q, w_state_d;
  logic [3:0]      w_id_q, w_id_d, w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic [IdxW-1:0] w_idx_q, w_idx_d;
  logic            proto_err_q, proto_err_d;
  logic            mem_we, w_last;

  r_state_e              r_state_q, r_state_d;
  logic [3:0]            r_id_q, r_id_d, r_len_q, r_len_d, r_cnt_q, r_cnt_d, r_lat_q, r_lat_d;
  logic [IdxW-1:0]       r_idx_q, r_idx_d;
  logic                  r_show_q, r_show_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  r_last;

  logic bp_ready, bp_rvalid;

`ifdef AXI_MEM_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= LFSR_SEED;
    else     lfsr_q <= lfsr_d;
  end
  assign bp_ready  = lfsr_q[0];
  assign bp_rvalid = lfsr_q[1];
`else
  logic [15:0] unused_seed;
  assign unused_seed = LFSR_SEED;
  assign bp_ready    = 1'b1;
  assign bp_rvalid   = 1'b1;
`endif

  // Upper address bits alias and the byte offset is ignored.
  logic unused_addr;
  assign unused_addr = ^{AWADDR[ADDR_WIDTH-1:IdxW+2], AWADDR[1:0],
                         ARADDR[ADDR_WIDTH-1:IdxW+2], ARADDR[1:0]};

  assign w_last = (w_cnt_q == w_len_q);

  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_idx_d     = w_idx_q;
    proto_err_d = proto_err_q;
    mem_we      = 1'b0;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    case (w_state_q)
      WIdle: begin
        AWREADY = bp_ready;
        if (AWVALID && bp_ready) begin
          w_id_d    = AWID;
          w_len_d   = AWLEN;
          w_idx_d   = AWADDR[IdxW+1:2];
          w_cnt_d   = 4'd0;
          w_state_d = WData;
        end
      end
      WData: begin
        WREADY = bp_ready;
        if (WVALID && bp_ready) begin
          mem_we  = 1'b1;
          w_idx_d = w_idx_q + IdxW'(1);
          w_cnt_d = w_cnt_q + 4'd1;
          if ((WID != w_id_q) || (WLAST != w_last)) proto_err_d = 1'b1;
          // Termination follows the beat counter only; WLAST is merely checked.
          if (w_last) w_state_d = WResp;
        end
      end
      WResp: begin
        BVALID = 1'b1;
        if (BREADY) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign r_last = (r_cnt_q == r_len_q);

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_len_d   = r_len_q;
    r_cnt_d   = r_cnt_q;
    r_lat_d   = r_lat_q;
    r_idx_d   = r_idx_q;
    r_show_d  = r_show_q;
    rdata_d   = rdata_q;
    ARREADY   = 1'b0;
    RVALID    = 1'b0;
    RLAST     = 1'b0;
    case (r_state_q)
      RIdle: begin
        ARREADY = bp_ready;
        if (ARVALID && bp_ready) begin
          r_id_d    = ARID;
          r_len_d   = ARLEN;
          r_idx_d   = ARADDR[IdxW+1:2];
          r_cnt_d   = 4'd0;
          r_lat_d   = 4'(READ_LATENCY - 1);
          r_state_d = RWait;
        end
      end
      RWait: begin
        if (r_lat_q == 4'd0) begin
          rdata_d   = mem_q[r_idx_q];
          r_idx_d   = r_idx_q + IdxW'(1);
          r_show_d  = 1'b1;
          r_state_d = RBurst;
        end else begin
          r_lat_d = r_lat_q - 4'd1;
        end
      end
      RBurst: begin
        // r_show_q keeps a beat visible once offered, so throttling never retracts it.
        RVALID = r_show_q | bp_rvalid;
        RLAST  = RVALID & r_last;
        if (RVALID && RREADY) begin
          r_show_d = 1'b0;
          if (r_last) begin
            r_state_d = RIdle;
          end else begin
            rdata_d = mem_q[r_idx_q];
            r_idx_d = r_idx_q + IdxW'(1);
            r_cnt_d = r_cnt_q + 4'd1;
          end
        end else if (RVALID) begin
          r_show_d = 1'b1;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q   <= WIdle;
      w_id_q      <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      w_idx_q     <= '0;
      proto_err_q <= 1'b0;
      r_state_q   <= RIdle;
      r_id_q      <= '0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      r_lat_q     <= '0;
      r_idx_q     <= '0;
      r_show_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      w_state_q   <= w_state_d;
      w_id_q      <= w_id_d;
      w_len_q     <= w_len_d;
      w_cnt_q     <= w_cnt_d;
      w_idx_q     <= w_idx_d;
      proto_err_q <= proto_err_d;
      r_state_q   <= r_state_d;
      r_id_q      <= r_id_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
      r_lat_q     <= r_lat_d;
      r_idx_q     <= r_idx_d;
      r_show_q    <= r_show_d;
      rdata_q     <= rdata_d;
    end
  end

  // Reads sample mem_q before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[w_idx_q] <= WDATA;
  end

  assign BID       = w_id_q;
  assign RID       = r_id_q;
  assign RDATA     = rdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed self-checking bench for axi_mem_responder (default build, no backpressure).
module tb_axi_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, RLAST, proto_err;
  logic [3:0]  AWID, AWLEN, WID, BID, ARID, ARLEN, RID;
  logic [25:0] AWADDR, ARADDR;
  logic [31:0] WDATA, RDATA;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_mem_responder dut (
    .clk      (clk),
    .rst      (rst),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .AWID     (AWID),
    .AWLEN    (AWLEN),
    .AWADDR   (AWADDR),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .WLAST    (WLAST),
    .WID      (WID),
    .WDATA    (WDATA),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .BID      (BID),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .ARID     (ARID),
    .ARLEN    (ARLEN),
    .ARADDR   (ARADDR),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .RLAST    (RLAST),
    .RID      (RID),
    .RDATA    (RDATA),
    .proto_err(proto_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Beat i carries base+i; early_last forces WLAST on that beat index (-1 for none).
  task automatic axi_write(input logic [25:0] addr, input logic [3:0] id, input logic [3:0] len,
                           input logic [31:0] base, input logic [3:0] wid, input int early_last);
    int n;
    AWVALID = 1'b1; AWADDR = addr; AWID = id; AWLEN = len;
    n = 0;
    while (!AWREADY && n < 50) begin step(); n++; end
    chk("aw_ready_wait", 32'(n < 50), 32'd1);
    step();
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1'b1; WDATA = base + 32'(i); WID = wid;
      WLAST  = (i == int'(len)) || (i == early_last);
      n = 0;
      while (!WREADY && n < 50) begin step(); n++; end
      chk("w_ready_wait", 32'(n < 50), 32'd1);
      step();
    end
    WVALID = 1'b0; WLAST = 1'b0;
    BREADY = 1'b1;
    n = 0;
    while (!BVALID && n < 50) begin step(); n++; end
    chk("b_valid_wait", 32'(n < 50), 32'd1);
    chk("bid", 32'(BID), 32'(id));
    step();
    BREADY = 1'b0;
    chk("aw_ready_after_b", 32'(AWREADY), 32'd1);
  endtask

  // Expects beat i == base+i; optionally stalls RREADY on one beat and checks stability.
  task automatic axi_read(input logic [25:0] addr, input logic [3:0] id, input logic [3:0] len,
                          input logic [31:0] base, input int stall_beat, input int stall_cycles);
    int n;
    ARVALID = 1'b1; ARADDR = addr; ARID = id; ARLEN = len;
    n = 0;
    while (!ARREADY && n < 50) begin step(); n++; end
    chk("ar_ready_wait", 32'(n < 50), 32'd1);
    step();
    ARVALID = 1'b0;
    n = 0;
    while (!RVALID && n < 50) begin step(); n++; end
    chk("r_latency", 32'(n), 32'd2);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!RVALID && n < 50) begin step(); n++; end
      if (i > 0) chk("r_no_bubble", 32'(n), 32'd0);
      chk("rdata", RDATA, base + 32'(i));
      chk("rid", 32'(RID), 32'(id));
      chk("rlast", 32'(RLAST), 32'(i == int'(len)));
      if (i == stall_beat) begin
        for (int s = 0; s < stall_cycles; s++) begin
          step();
          chk("stall_rvalid", 32'(RVALID), 32'd1);
          chk("stall_rdata", RDATA, base + 32'(i));
          chk("stall_rlast", 32'(RLAST), 32'(i == int'(len)));
        end
      end
      RREADY = 1'b1;
      step();
      RREADY = 1'b0;
    end
    chk("r_done_rvalid", 32'(RVALID), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    AWVALID = 1'b0; AWID = '0; AWLEN = '0; AWADDR = '0;
    WVALID = 1'b0; WLAST = 1'b0; WID = '0; WDATA = '0; BREADY = 1'b0;
    ARVALID = 1'b0; ARID = '0; ARLEN = '0; ARADDR = '0; RREADY = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    chk("rst_awready", 32'(AWREADY), 32'd1);
    chk("rst_arready", 32'(ARREADY), 32'd1);
    chk("rst_wready", 32'(WREADY), 32'd0);
    chk("rst_bvalid", 32'(BVALID), 32'd0);
    chk("rst_rvalid", 32'(RVALID), 32'd0);
    chk("rst_rlast", 32'(RLAST), 32'd0);
    chk("rst_proto_err", 32'(proto_err), 32'd0);
    chk("rst_bid", 32'(BID), 32'd0);
    chk("rst_rid", 32'(RID), 32'd0);
    chk("rst_rdata", RDATA, 32'd0);

    // Single write then read.
    axi_write(26'h100, 4'd3, 4'd0, 32'hDEADBEEF, 4'd3, -1);
    chk("single_proto_err", 32'(proto_err), 32'd0);
    axi_read(26'h100, 4'd5, 4'd0, 32'hDEADBEEF, -1, 0);

    // Four-beat burst, beat 2 stalled for three cycles.
    axi_write(26'h200, 4'd4, 4'd3, 32'h1, 4'd4, -1);
    axi_read(26'h200, 4'd9, 4'd3, 32'h1, 1, 3);

    // Index wrap: word 0xFFFF then word 0.
    axi_write(26'h3FFFC, 4'd1, 4'd1, 32'hA0, 4'd1, -1);
    axi_read(26'h0, 4'd2, 4'd0, 32'hA1, -1, 0);
    axi_read(26'h3FFFC, 4'd2, 4'd1, 32'hA0, -1, 0);

    // WID mismatch: flag set, burst still runs four beats.
    axi_write(26'h300, 4'd2, 4'd3, 32'h50, 4'd7, -1);
    chk("wid_proto_err", 32'(proto_err), 32'd1);
    axi_read(26'h300, 4'd0, 4'd3, 32'h50, -1, 0);
    chk("proto_err_sticky", 32'(proto_err), 32'd1);

    // Reset in the middle of a read burst.
    ARVALID = 1'b1; ARADDR = 26'h200; ARID = 4'd6; ARLEN = 4'd3;
    step();
    ARVALID = 1'b0;
    step(); step();
    chk("mid_rvalid", 32'(RVALID), 32'd1);
    chk("mid_rdata0", RDATA, 32'h1);
    RREADY = 1'b1;
    step();
    RREADY = 1'b0;
    chk("mid_rdata1", RDATA, 32'h2);
    rst = 1'b1;
    step();
    chk("mid_rst_rvalid", 32'(RVALID), 32'd0);
    chk("mid_rst_arready", 32'(ARREADY), 32'd1);
    chk("mid_rst_proto_err", 32'(proto_err), 32'd0);
    rst = 1'b0;
    step(); step();
    chk("post_rst_rvalid", 32'(RVALID), 32'd0);

    // Early WLAST on beat 1 of a 4-beat burst.
    axi_write(26'h300, 4'd2, 4'd3, 32'h60, 4'd2, 0);
    chk("wlast_proto_err", 32'(proto_err), 32'd1);
    axi_read(26'h300, 4'd1, 4'd3, 32'h60, -1, 0);

    // Same-cycle RAM read and W write to word 0x40: read sees old value.
    axi_write(26'h100, 4'd1, 4'd0, 32'h11, 4'd1, -1);
    AWVALID = 1'b1; AWADDR = 26'h100; AWID = 4'd1; AWLEN = 4'd0;
    step();
    AWVALID = 1'b0;
    ARVALID = 1'b1; ARADDR = 26'h100; ARID = 4'd4; ARLEN = 4'd0;
    step();
    ARVALID = 1'b0;
    step();
    WVALID = 1'b1; WDATA = 32'h22; WID = 4'd1; WLAST = 1'b1;
    chk("rbw_wready", 32'(WREADY), 32'd1);
    step();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("rbw_rvalid", 32'(RVALID), 32'd1);
    chk("rbw_rdata_old", RDATA, 32'h11);
    chk("rbw_bvalid", 32'(BVALID), 32'd1);
    RREADY = 1'b1; BREADY = 1'b1;
    step();
    RREADY = 1'b0; BREADY = 1'b0;
    axi_read(26'h100, 4'd4, 4'd0, 32'h22, -1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
- AXI-style memory slave; the responder end of the core's external AXI master interface (AW/W/B/AR/R channels, 4-bit IDs, 4-bit LEN).
- Used as the simulation and FPGA backing store behind the memory arbiter; serves i-cache and d-cache line fills and d-cache write-backs.
- Read and write paths are independent FSMs sharing one word-addressed RAM array.

Parameters:
- ADDR_WIDTH, 26, byte-address width (matches `ADDR_WIDTH).
- DATA_WIDTH, 32, beat width (matches `DATA_WIDTH).
- MEM_WORDS_LOG2, 16, log2 of RAM depth in words.
- READ_LATENCY, 2, cycles from AR handshake to first RVALID; legal range 1..15.
- LFSR_SEED, 16'hACE1, seed for the optional backpressure generator.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- AWVALID in 1; AWREADY out 1; AWID in 4; AWLEN in 4; AWADDR in ADDR_WIDTH.
- WVALID in 1; WREADY out 1; WLAST in 1; WID in 4; WDATA in DATA_WIDTH.
- BVALID out 1; BREADY in 1; BID out 4.
- ARVALID in 1; ARREADY out 1; ARID in 4; ARLEN in 4; ARADDR in ADDR_WIDTH.
- RVALID out 1; RREADY in 1; RLAST out 1; RID out 4; RDATA out DATA_WIDTH.
- proto_err  out  1  sticky protocol-violation flag.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - AWREADY=1, ARREADY=1.
  - WREADY, BVALID, RVALID, RLAST, proto_err = 0.
  - BID, RID, RDATA = 0.
  - Both FSMs go to IDLE. RAM contents are not cleared.
  - Reset mid-burst abandons the burst; no B or R beats follow.
- Addressing: word index = ADDR[MEM_WORDS_LOG2+1:2]. Upper bits alias; byte offset is ignored. Each burst beat increments the index by 1, wrapping modulo 2^MEM_WORDS_LOG2. A burst carries LEN+1 beats (1..16).
- Write FSM (W_IDLE, W_DATA, W_RESP):
  - W_IDLE: AWREADY=1. On AWVALID&AWREADY, latch AWID, AWLEN and the start index; clear the beat counter; go to W_DATA.
  - W_DATA: AWREADY=0, WREADY=1. Each WVALID&WREADY writes WDATA to RAM at that edge and increments the index and counter. The burst ends on the beat where counter==LEN; then go to W_RESP.
  - W_RESP: BVALID=1, BID=latched ID. Hold both until BREADY; on BVALID&BREADY go to W_IDLE. AWREADY returns 1 on the following cycle.
  - W beats are accepted only in W_DATA; W data arriving before AW is stalled (WREADY=0).
- Read FSM (R_IDLE, R_WAIT, R_BURST):
  - R_IDLE: ARREADY=1. On ARVALID&ARREADY, latch ARID, ARLEN and the index; load the latency counter with READY_LATENCY-1; go to R_WAIT.
  - R_WAIT: ARREADY=0. Count down; on zero, register RAM[index] into RDATA and go to R_BURST. First RVALID is asserted exactly READ_LATENCY cycles after the AR handshake edge.
  - R_BURST: RVALID=1, RID=latched ID, RLAST=1 on the final beat. RDATA, RID and RLAST stay stable while RVALID&!RREADY.
  - On each handshake, the next beat is valid the very next cycle (no bubbles). After the last handshake, drop RVALID and go to R_IDLE.
- Simultaneous events:
  - Read and write to the same word in the same cycle: the read returns the old data (read-before-write).
  - AW and AR handshakes may occur in the same cycle; the two FSMs are fully independent.
- proto_err is set, and held until rst, on any of:
  - a W handshake with WID != latched AWID;
  - WLAST != (counter==LEN) on a W handshake;
  - RREADY-independent checks: none.
  - Burst termination always follows the counter, never WLAST.

Optional Feature:
- Macro AXI_MEM_BACKPRESSURE_EN.
- Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with LFSR_SEED on rst, advances every cycle.
  - AWREADY, ARREADY and WREADY are additionally ANDed with lfsr[0].
  - In R_BURST, beats after the first are withheld (RVALID=0) for one cycle whenever lfsr[1]=0.
  - All stability and handshake rules still hold.
- Undefined: no LFSR; timing is exactly as above.

Test Plan:
- Single write then read: AW(addr 0x100, ID 3, LEN 0) with W(0xDEADBEEF, WLAST=1) -> BVALID with BID=3. Then AR(0x100, ID 5, LEN 0) -> RVALID exactly 2 cycles after the handshake, RDATA=0xDEADBEEF, RID=5, RLAST=1.
- 4-beat burst with RREADY stall: write 0x1..0x4 at 0x200 with LEN 3. Read back holding RREADY low for 3 cycles on beat 2 -> beats 1,2,3,4 in order, beat 2 held stable, RLAST only on beat 4.
- Wrap: MEM_WORDS_LOG2=4, 2-beat write at word 15 -> second beat lands in word 0; reading word 0 returns it.
- Protocol error: WID=7 while AWID=2, or WLAST=1 on beat 1 of LEN 3 -> proto_err=1 and held. The burst still consumes 4 beats and B returns BID=2.
- Concurrency and reset: a same-cycle AR and W to word 0x40 (old 0x11, new 0x22) -> read returns 0x11. Asserting rst mid-read-burst -> RVALID=0 next cycle and ARREADY=1.
- With AXI_MEM_BACKPRESSURE_EN: random 100-burst read/write traffic against a scoreboard -> all data matches and no payload changes while VALID&!READY.
